// File: rtl/mcc_pkg.sv
// Shared types and constants for the multicycle controller: FSM state encoding,
// the all-zero halt opcode and the sequential PC step.
package mcc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALT
    } state_t;

    localparam logic [31:0] HALT_INSTR = 32'h0000_0000;
    localparam int unsigned PC_INCR    = 4;

endpackage

// File: rtl/multicycle_ctrl_pc_reg.sv
// Program counter register with next-PC select (PC+4 or PC+imm).
// Latency: loads on the clock edge after load=1. Backpressure: none, holds while load=0.
// Sums wrap modulo 2^WIDTH.
module pc_reg
    import mcc_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             sel_imm,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] pc
);

    logic [WIDTH-1:0] pc_next;

    always_comb begin
        pc_next = sel_imm ? (pc + imm) : (pc + WIDTH'(PC_INCR));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle fetch/decode/exec/writeback sequencer; an all-zero fetched word halts until reset.
// Latency: 4 cycles per instruction from the imem_ack cycle. Backpressure: waits in FETCH with imem_req high until imem_ack.
// Optional MCC_PERF_CNT_EN adds an instret retired-instruction counter output.
module multicycle_ctrl
    import mcc_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic [WIDTH-1:0] PC,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] RD,
    output logic [WIDTH-1:0] instr,
    input  logic             RegWrite,
    input  logic             PCsrc,
    input  logic [WIDTH-1:0] ImmOp,
    output logic             reg_we,
    output logic             halted
`ifdef MCC_PERF_CNT_EN
    ,
    output logic [WIDTH-1:0] instret
`endif
);

    state_t           state_q, state_d;
    logic             ir_load, imm_load, pc_load;
    logic [WIDTH-1:0] imm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        reg_we   = 1'b0;
        halted   = 1'b0;
        ir_load  = 1'b0;
        imm_load = 1'b0;
        pc_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    // A halt word is never loaded into the IR.
                    if (RD == WIDTH'(HALT_INSTR)) begin
                        state_d = HALT;
                    end else begin
                        ir_load = 1'b1;
                        state_d = DECODE;
                    end
                end
            end
            DECODE: begin
                imm_load = 1'b1;
                state_d  = EXEC;
            end
            EXEC: begin
                state_d = WB;
            end
            WB: begin
                reg_we  = RegWrite;
                pc_load = 1'b1;
                state_d = run ? FETCH : IDLE;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= '0;
            imm_q <= '0;
        end else begin
            if (ir_load)  instr <= RD;
            if (imm_load) imm_q <= ImmOp;
        end
    end

    pc_reg #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (pc_load),
        .sel_imm (PCsrc),
        .imm     (imm_q),
        .pc      (PC)
    );

`ifdef MCC_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (state_q == WB) begin
            instret <= instret + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; inputs change just after the
// falling edge and outputs are sampled there, half a period away from the active edge.
module tb_multicycle_ctrl;

    localparam logic [31:0] ADDI5  = 32'h0050_0093;
    localparam logic [31:0] ADDI10 = 32'h00A0_0113;
    localparam logic [31:0] JAL    = 32'h0000_006F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [31:0] PC;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] RD;
    logic [31:0] instr;
    logic        RegWrite;
    logic        PCsrc;
    logic [31:0] ImmOp;
    logic        reg_we;
    logic        halted;
`ifdef MCC_PERF_CNT_EN
    logic [31:0] instret;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .PC       (PC),
        .imem_req (imem_req),
        .imem_ack (imem_ack),
        .RD       (RD),
        .instr    (instr),
        .RegWrite (RegWrite),
        .PCsrc    (PCsrc),
        .ImmOp    (ImmOp),
        .reg_we   (reg_we),
        .halted   (halted)
`ifdef MCC_PERF_CNT_EN
        ,
        .instret  (instret)
`endif
    );

    task automatic test_reset();
        rst_n = 1'b1; run = 1'b0; imem_ack = 1'b0; RD = '0;
        RegWrite = 1'b0; PCsrc = 1'b0; ImmOp = '0;
        #1 rst_n = 1'b0;
        #2;
        n_cmp++; if (PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0); end
        n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want %h", instr, 32'h0); end
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_cmp++; if (reg_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", reg_we); end
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
`ifdef MCC_PERF_CNT_EN
        n_cmp++; if (instret !== 32'h0) begin n_fail++; $display("FAIL reset_instret: got %h want 0", instret); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Zero-wait memory, addi x1,x0,5: PC 0 -> 4 -> 8, one reg_we pulse per 4 cycles.
    task automatic test_basic();
        int we_cnt;
        RD = ADDI5; RegWrite = 1'b1; PCsrc = 1'b0; ImmOp = 32'd5; imem_ack = 1'b1; run = 1'b1;
        @(negedge clk);
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL basic_req_fetch: got %b want 1", imem_req); end
        n_cmp++; if (PC !== 32'h0) begin n_fail++; $display("FAIL basic_pc_fetch: got %h want 0", PC); end
        @(negedge clk);
        n_cmp++; if (instr !== ADDI5) begin n_fail++; $display("FAIL basic_instr: got %h want %h", instr, ADDI5); end
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_decode: got %b want 0", imem_req); end
        @(negedge clk);
        n_cmp++; if (reg_we !== 1'b0) begin n_fail++; $display("FAIL basic_we_exec: got %b want 0", reg_we); end
        @(negedge clk);
        n_cmp++; if (reg_we !== 1'b1) begin n_fail++; $display("FAIL basic_we_wb: got %b want 1", reg_we); end
        n_cmp++; if (PC !== 32'h0) begin n_fail++; $display("FAIL basic_pc_wb: got %h want 0", PC); end
        @(negedge clk);
        n_cmp++; if (PC !== 32'h4) begin n_fail++; $display("FAIL basic_pc_next: got %h want 4", PC); end
        n_cmp++; if (reg_we !== 1'b0) begin n_fail++; $display("FAIL basic_we_after: got %b want 0", reg_we); end
        we_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (reg_we === 1'b1) we_cnt++;
            if (i == 2) begin
                n_cmp++; if (PC !== 32'h4) begin n_fail++; $display("FAIL basic_pc_hold: got %h want 4", PC); end
            end
        end
        n_cmp++; if (PC !== 32'h8) begin n_fail++; $display("FAIL basic_pc_second: got %h want 8", PC); end
        n_cmp++; if (we_cnt != 1) begin n_fail++; $display("FAIL basic_we_count: got %0d want 1", we_cnt); end
    endtask

    // Ack withheld 3 cycles, then a PC-relative branch of -8 from PC=8 with RegWrite=0.
    task automatic test_wait_ack_branch();
        imem_ack = 1'b0; RD = ADDI10; RegWrite = 1'b0; PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL wait_req_%0d: got %b want 1", i, imem_req); end
            n_cmp++; if (PC !== 32'h8) begin n_fail++; $display("FAIL wait_pc_%0d: got %h want 8", i, PC); end
            n_cmp++; if (instr !== ADDI5) begin n_fail++; $display("FAIL wait_instr_%0d: got %h want %h", i, instr, ADDI5); end
        end
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        n_cmp++; if (instr !== ADDI10) begin n_fail++; $display("FAIL wait_instr_ack: got %h want %h", instr, ADDI10); end
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL wait_req_ack: got %b want 0", imem_req); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (reg_we !== 1'b0) begin n_fail++; $display("FAIL branch_we: got %b want 0", reg_we); end
        @(negedge clk);
        n_cmp++; if (PC !== 32'h0) begin n_fail++; $display("FAIL branch_pc: got %h want 0", PC); end
    endtask

    // PC 0 + FFFFFFFC -> FFFFFFFC, then +4 wraps to 0.
    task automatic test_pc_wrap();
        RD = JAL; RegWrite = 1'b0; PCsrc = 1'b1; ImmOp = 32'hFFFF_FFFC; imem_ack = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (PC !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc_neg: got %h want fffffffc", PC); end
        PCsrc = 1'b0; RegWrite = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (PC !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_zero: got %h want 0", PC); end
    endtask

    // run dropped in DECODE: instruction still writes back, then controller parks in IDLE.
    task automatic test_run_drop();
        RD = ADDI5; RegWrite = 1'b1; PCsrc = 1'b0; ImmOp = 32'd5; imem_ack = 1'b1;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (reg_we !== 1'b1) begin n_fail++; $display("FAIL rundrop_we: got %b want 1", reg_we); end
        @(negedge clk);
        n_cmp++; if (PC !== 32'h4) begin n_fail++; $display("FAIL rundrop_pc: got %h want 4", PC); end
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rundrop_req: got %b want 0", imem_req); end
        RD = ADDI10;
        @(negedge clk);
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rundrop_idle_req: got %b want 0", imem_req); end
        n_cmp++; if (instr !== ADDI5) begin n_fail++; $display("FAIL rundrop_instr: got %h want %h", instr, ADDI5); end
    endtask

    // Reset pulled mid-EXEC and mid-FETCH between clock edges.
    task automatic test_async_reset();
        RD = ADDI10; imem_ack = 1'b1; run = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (PC !== 32'h0) begin n_fail++; $display("FAIL arst_pc: got %h want 0", PC); end
        n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL arst_instr: got %h want 0", instr); end
        n_cmp++; if (reg_we !== 1'b0 || imem_req !== 1'b0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL arst_ctrl: got we=%b req=%b halted=%b want 0 0 0", reg_we, imem_req, halted);
        end
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL arst_stale_ack: got %h want 0", instr); end
        imem_ack = 1'b0; run = 1'b1;
        @(negedge clk);
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL arst_fetch_req: got %b want 1", imem_req); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL arst_req_drop: got %b want 0", imem_req); end
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One instruction, then a zero word halts; run ignored; reset recovers.
    task automatic test_halt();
        RD = ADDI5; RegWrite = 1'b1; PCsrc = 1'b0; imem_ack = 1'b1; run = 1'b1;
        repeat (5) @(negedge clk);
        RD = 32'h0;
        @(negedge clk);
        n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b want 1", halted); end
        n_cmp++; if (PC !== 32'h4) begin n_fail++; $display("FAIL halt_pc: got %h want 4", PC); end
        n_cmp++; if (instr !== ADDI5) begin n_fail++; $display("FAIL halt_instr: got %h want %h", instr, ADDI5); end
        for (int i = 0; i < 4; i++) begin
            run = i[0];
            @(negedge clk);
            n_cmp++; if (halted !== 1'b1 || imem_req !== 1'b0) begin
                n_fail++; $display("FAIL halt_stick_%0d: got halted=%b req=%b want 1 0", i, halted, imem_req);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset_flag: got %b want 0", halted); end
        n_cmp++; if (PC !== 32'h0) begin n_fail++; $display("FAIL halt_reset_pc: got %h want 0", PC); end
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (halted !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL halt_idle: got halted=%b req=%b want 0 0", halted, imem_req);
        end
    endtask

    // Ten instructions back to back then halt: PC=40, instret=10 when counting is built in.
    task automatic test_back_to_back();
        RD = ADDI5; RegWrite = 1'b1; PCsrc = 1'b0; ImmOp = 32'd5; imem_ack = 1'b1; run = 1'b1;
        repeat (41) @(negedge clk);
        RD = 32'h0;
        @(negedge clk);
        n_cmp++; if (PC !== 32'd40) begin n_fail++; $display("FAIL b2b_pc: got %0d want 40", PC); end
        n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL b2b_halted: got %b want 1", halted); end
`ifdef MCC_PERF_CNT_EN
        n_cmp++; if (instret !== 32'd10) begin n_fail++; $display("FAIL b2b_instret: got %0d want 10", instret); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_ack_branch();
        test_pc_wrap();
        test_run_drop();
        test_async_reset();
        test_halt();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
